gf2m_ds_mul: RTL and testbench

GF2M_DS_MUL -- requirements
Module: gf2m_ds_mul

---
 rtl/gf2m_pkg.sv | 21 ++
 rtl/gf2m_digit_step.sv | 35 +++
 rtl/gf2m_ds_mul.sv | 106 ++++++++++
 tb/tb_gf2m_ds_mul.sv | 372 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gf2m_pkg.sv
// Shared definitions for the digit-serial GF(2^m) multiplier: controller states,
// standard NIST reduction polynomials and the digit-count helper.
package gf2m_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Low M bits of f(x); the x^M term is implicit.
    localparam int           GF_M163    = 163;
    localparam logic [162:0] GF_POLY163 = 163'hC9;
    localparam int           GF_M233    = 233;
    localparam logic [232:0] GF_POLY233 = (233'd1 << 74) | 233'd1;

    function automatic int ceil_div(input int num, input int den);
        return (num + den - 1) / den;
    endfunction

endpackage

// File: rtl/gf2m_digit_step.sv
// One digit-serial step: (acc * x^D + a * digit) mod f(x), purely combinational.
// Evaluated Horner-style, one multiply-by-x with reduction per digit bit.
module gf2m_digit_step
    import gf2m_pkg::*;
#(
    parameter int          M    = GF_M163,
    parameter int          D    = 16,
    parameter logic [M-1:0] POLY = M'(GF_POLY163)
) (
    input  logic [M-1:0] i_acc,
    input  logic [M-1:0] i_a,
    input  logic [D-1:0] i_digit,
    output logic [M-1:0] o_next
);

    // Reducing x^M terms that land on bit M-D or above would need a second pass.
    if ((D < 1) || (D > M)) begin : g_bad_digit
        $error("gf2m_digit_step: digit width D must satisfy 1 <= D <= M");
    end
    if ((POLY >> (M - D)) != '0) begin : g_bad_poly
        $error("gf2m_digit_step: POLY has terms at or above bit M-D");
    end

    function automatic logic [M-1:0] mul_x(input logic [M-1:0] v);
        return {v[M-2:0], 1'b0} ^ (v[M-1] ? POLY : '0);
    endfunction

    always_comb begin
        o_next = i_acc;
        for (int j = D - 1; j >= 0; j--) begin
            o_next = mul_x(o_next) ^ (i_digit[j] ? i_a : '0);
        end
    end

endmodule

// File: rtl/gf2m_ds_mul.sv
// Digit-serial GF(2^m) multiplier/squarer: latches operands, consumes D bits of b
// per cycle MSD-first for NDIG cycles, then presents the reduced product.
module gf2m_ds_mul
    import gf2m_pkg::*;
#(
    parameter int           M    = GF_M163,
    parameter int           D    = 16,
    parameter logic [M-1:0] POLY = M'(GF_POLY163)
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         mode,
    input  logic [M-1:0] a,
    input  logic [M-1:0] b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [M-1:0] result,
    output logic         busy,
    output logic [1:0]   dbg_state
);

    localparam int             NDIG     = ceil_div(M, D);
    localparam int             BW       = NDIG * D;
    localparam int             CW       = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [CW-1:0]  LAST_CNT = CW'(NDIG - 1);

    state_t          r_state;
    logic [M-1:0]    r_a;
    logic [BW-1:0]   r_b;
    logic [M-1:0]    r_acc;
    logic [CW-1:0]   r_cnt;

    logic            w_accept;
    logic [D-1:0]    w_digit;
    logic [M-1:0]    w_next_acc;

    // Both sides use valid/ready: a transfer happens on a rising edge where valid
    // and ready are both high; result is held stable while out_valid & !out_ready.
    assign in_ready  = (r_state == ST_IDLE) || ((r_state == ST_DONE) && out_ready);
    assign w_accept  = in_valid && in_ready;
    assign out_valid = (r_state == ST_DONE);
    assign busy      = (r_state == ST_RUN);
    assign result    = (r_state == ST_DONE) ? r_acc : '0;
    assign dbg_state = r_state;

    // b is zero-padded at the MSB end, so the top digit of r_b is always next.
    assign w_digit = r_b[BW-1 -: D];

    gf2m_digit_step #(
        .M    (M),
        .D    (D),
        .POLY (POLY)
    ) u_step (
        .i_acc   (r_acc),
        .i_a     (r_a),
        .i_digit (w_digit),
        .o_next  (w_next_acc)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= ST_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_acc   <= '0;
            r_cnt   <= '0;
        end else if (w_accept) begin
            r_a     <= a;
            r_b     <= BW'(mode ? a : b);
            r_acc   <= '0;
            r_cnt   <= '0;
            r_state <= ST_RUN;
        end else begin
            case (r_state)
                ST_RUN: begin
                    r_acc <= w_next_acc;
                    r_b   <= r_b << D;
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == LAST_CNT) begin
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_IDLE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    a_hold_result: assert property (@(posedge clk) disable iff (!rstn)
        (out_valid && !out_ready) |=> (out_valid && $stable(result)));

    a_zero_idle: assert property (@(posedge clk) disable iff (!rstn)
        !out_valid |-> (result == '0));

endmodule

// File: tb/tb_gf2m_ds_mul.sv
// Bench for gf2m_ds_mul: schoolbook-multiply reference model with per-cycle compare,
// plus directed vectors for the M=163/D=16 and M=8/D=3 configurations.
module tb_gf2m_ds_mul;

    localparam int M     = 163;
    localparam int D     = 16;
    localparam int NDIG  = 11;
    localparam int NDIG8 = 3;

    logic         clk;
    logic         rstn;
    logic         in_valid, in_ready, mode, out_valid, out_ready, busy;
    logic [M-1:0] a, b, result;
    logic [1:0]   dbg_state;
    logic         in_valid8, in_ready8, mode8, out_valid8, out_ready8, busy8;
    logic [7:0]   a8, b8, result8;
    logic [1:0]   dbg_state8;

    int           total;
    int           bad;
    bit           chk_en;
    logic [M-1:0] exp_q[$];
    int           m_left;
    bit           m_done;
    int           cyc;
    int           last_done_cyc;
    bit           chk_period;
    int           n_b2b;

    gf2m_ds_mul #(.M(M), .D(D), .POLY(163'hC9)) u_dut (
        .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready), .mode(mode),
        .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .busy(busy), .dbg_state(dbg_state)
    );

    gf2m_ds_mul #(.M(8), .D(3), .POLY(8'h1B)) u_dut8 (
        .clk(clk), .rstn(rstn), .in_valid(in_valid8), .in_ready(in_ready8), .mode(mode8),
        .a(a8), .b(b8), .out_valid(out_valid8), .out_ready(out_ready8), .result(result8),
        .busy(busy8), .dbg_state(dbg_state8)
    );

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [M-1:0] act, input logic [M-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        total++;
        bad++;
        $display("FAIL %s: no response within cycle budget", name);
    endtask

    // Reference: full polynomial product, then long-division reduction by f(x).
    function automatic logic [M-1:0] gf_mul(input logic [M-1:0] x, input logic [M-1:0] y);
        logic [2*M-2:0] p;
        logic [2*M-2:0] f;
        logic [2*M-2:0] xe;
        p  = '0;
        xe = '0;
        xe[M-1:0] = x;
        for (int i = 0; i < M; i++) begin
            if (y[i]) p ^= (xe << i);
        end
        f = '0;
        f[M] = 1'b1;
        f[7:0] = 8'hC9;
        for (int i = 2*M-2; i >= M; i--) begin
            if (p[i]) p ^= (f << (i - M));
        end
        return p[M-1:0];
    endfunction

    function automatic logic [M-1:0] rand_op();
        logic [191:0] t;
        t = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        return t[M-1:0];
    endfunction

    function automatic logic [M-1:0] xpow(input int n);
        logic [M-1:0] v;
        v = '0;
        v[n] = 1'b1;
        return v;
    endfunction

    // ---------------- behavioural model + compare process ----------------
    task automatic model_reset();
        m_left = 0;
        m_done = 1'b0;
        exp_q.delete();
    endtask

    task automatic model_step();
        bit acc;
        cyc++;
        if (!rstn) begin
            model_reset();
            return;
        end
        acc = in_valid && (m_left == 0) && (!m_done || out_ready);
        if (m_left > 0) begin
            m_left--;
            if (m_left == 0) m_done = 1'b1;
        end else if (m_done && out_ready) begin
            m_done = 1'b0;
            if (exp_q.size() > 0) void'(exp_q.pop_front());
        end
        if (acc) begin
            exp_q.push_back(gf_mul(a, mode ? a : b));
            m_left = NDIG;
        end
    endtask

    task automatic check_outputs();
        logic [M-1:0] exp_res;
        if (!rstn) model_reset();
        exp_res = (m_done && exp_q.size() > 0) ? exp_q[0] : '0;
        check_int("cmp_out_valid", int'(out_valid), int'(m_done));
        check_int("cmp_busy", int'(busy), int'(m_left > 0));
        if (rstn) begin
            check_int("cmp_in_ready", int'(in_ready), int'((m_left == 0) && (!m_done || out_ready)));
        end
        check("cmp_result", result, exp_res);
        if (chk_period && out_valid) begin
            if (last_done_cyc >= 0) check_int("b2b_period", cyc - last_done_cyc, NDIG + 1);
            last_done_cyc = cyc;
            n_b2b++;
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            if (chk_en) model_step();
            @(negedge clk);
            if (chk_en) check_outputs();
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send(input logic [M-1:0] va, input logic [M-1:0] vb, input logic vm);
        int  n;
        bit  ok;
        @(posedge clk);
        #1;
        a = va; b = vb; mode = vm; in_valid = 1'b1;
        n = 0;
        ok = 1'b0;
        while (n < 100) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
            n++;
        end
        if (!ok) timeout_fail("send_accept");
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a = rand_op();
        b = rand_op();
    endtask

    // Called right after send(): returns at the first negedge showing out_valid.
    task automatic wait_result(output int lat);
        lat = 0;
        @(negedge clk);
        while (!out_valid && lat < 100) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        if (!out_valid) timeout_fail("wait_result");
    endtask

    task automatic run8(input string name, input logic [7:0] va, input logic [7:0] vb,
                        input logic vm, input logic [7:0] exp);
        int n;
        @(posedge clk);
        #1;
        a8 = va; b8 = vb; mode8 = vm; in_valid8 = 1'b1;
        @(negedge clk);
        check_int({name, "_rdy"}, int'(in_ready8), 1);
        @(posedge clk);
        #1;
        in_valid8 = 1'b0; a8 = 8'hFF; b8 = 8'hFF;
        n = 0;
        @(negedge clk);
        while (!out_valid8 && n < 20) begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end
        check_int({name, "_lat"}, n, NDIG8);
        check_int({name, "_res"}, int'(result8), int'(exp));
        check_int({name, "_busy"}, int'(busy8), 0);
        @(posedge clk);
        #1;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int lat;
        int n;
        logic [M-1:0] ones;
        total = 0; bad = 0; chk_en = 1'b0; cyc = 0; chk_period = 1'b0;
        last_done_cyc = -1; n_b2b = 0;
        m_left = 0; m_done = 1'b0;
        rstn = 1'b1;
        in_valid = 1'b0; mode = 1'b0; a = '0; b = '0; out_ready = 1'b1;
        in_valid8 = 1'b0; mode8 = 1'b0; a8 = '0; b8 = '0; out_ready8 = 1'b1;
        ones = '1;

        // Reference model pinned against hand-derived products.
        check("model_x_x162", gf_mul(xpow(1), xpow(162)), 163'hC9);
        check("model_sq_x81", gf_mul(xpow(81), xpow(81)), xpow(162));
        check("model_one", gf_mul(xpow(0), ones), ones);

        #2;
        rstn = 1'b0;
        chk_en = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rstn = 1'b1;
        @(negedge clk);
        check_int("reset_in_ready", int'(in_ready), 1);
        check_int("reset_out_valid", int'(out_valid), 0);
        check("reset_result", result, '0);
        check_int("reset_state", int'(dbg_state), int'(gf2m_pkg::ST_IDLE));
        check_int("reset_out_valid8", int'(out_valid8), 0);

        // Small field, AES polynomial, D not dividing M.
        run8("m8_57x83", 8'h57, 8'h83, 1'b0, 8'hC1);
        run8("m8_57x13", 8'h57, 8'h13, 1'b0, 8'hFE);
        run8("m8_57x10", 8'h57, 8'h10, 1'b0, 8'h07);
        run8("m8_sq_x4", 8'h10, 8'hAA, 1'b1, 8'h1B);
        run8("m8_sq_x1", 8'h02, 8'h55, 1'b1, 8'h04);

        // x * x^162 wraps exactly once into the reduction polynomial.
        send(xpow(1), xpow(162), 1'b0);
        wait_result(lat);
        check_int("x_x162_latency", lat, NDIG);
        check("x_x162_result", result, 163'hC9);
        repeat (2) @(posedge clk);

        send(xpow(81), rand_op(), 1'b1);
        wait_result(lat);
        check("square_x81", result, xpow(162));
        repeat (2) @(posedge clk);

        send(ones, xpow(0), 1'b0);
        wait_result(lat);
        check("ones_times_one", result, ones);
        repeat (2) @(posedge clk);

        for (int i = 0; i < 6; i++) begin
            send(rand_op(), rand_op(), 1'(i % 2));
            wait_result(lat);
            check_int("rand_latency", lat, NDIG);
            repeat (1) @(posedge clk);
        end
        repeat (2) @(posedge clk);

        // Consumer stalls for 5 cycles; extra requests must be ignored.
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        send(xpow(1), xpow(162), 1'b0);
        wait_result(lat);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            in_valid = 1'b1;
            a = rand_op();
            b = rand_op();
            @(negedge clk);
            check_int("stall_out_valid", int'(out_valid), 1);
            check_int("stall_in_ready", int'(in_ready), 0);
            check("stall_result", result, 163'hC9);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        check_int("stall_release_valid", int'(out_valid), 0);
        check_int("stall_release_ready", int'(in_ready), 1);
        repeat (2) @(posedge clk);

        // Reset in the middle of RUN discards the operation.
        send(rand_op(), rand_op(), 1'b0);
        repeat (4) @(posedge clk);
        #1;
        rstn = 1'b0;
        @(negedge clk);
        check_int("midrun_rst_valid", int'(out_valid), 0);
        check_int("midrun_rst_busy", int'(busy), 0);
        check("midrun_rst_result", result, '0);
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
        send(xpow(0), xpow(0), 1'b0);
        wait_result(lat);
        check_int("after_rst_latency", lat, NDIG);
        check("after_rst_one", result, xpow(0));
        repeat (3) @(posedge clk);

        // Back-to-back stream with valid and ready held high.
        last_done_cyc = -1;
        n_b2b = 0;
        chk_period = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        in_valid = 1'b1;
        a = rand_op(); b = rand_op(); mode = 1'($urandom_range(0, 1));
        for (int i = 0; i < 100; i++) begin
            n = 0;
            @(negedge clk);
            while (!in_ready && n < 100) begin
                @(negedge clk);
                n++;
            end
            if (!in_ready) timeout_fail("b2b_accept");
            @(posedge clk);
            #1;
            if (i < 99) begin
                a = rand_op(); b = rand_op(); mode = 1'($urandom_range(0, 1));
            end else begin
                in_valid = 1'b0;
            end
        end
        repeat (NDIG + 3) @(posedge clk);
        #1;
        chk_period = 1'b0;
        check_int("b2b_count", n_b2b, 100);

        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #900000;
        bad++;
        $display("FAIL watchdog: simulation exceeded time limit");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
